// File: rtl/timer_share_pkg.sv
// Shared types, defaults and round-robin selection for the timer share controller.
package timer_share_pkg;

    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned W_DEF    = 4;
    localparam int unsigned NREQ_MAX = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic        valid;
        int unsigned idx;
    } pick_t;

    // First set request bit at or above ptr, wrapping at nreq.
    function automatic pick_t rr_pick(input logic [NREQ_MAX-1:0] req,
                                      input int unsigned         ptr,
                                      input int unsigned         nreq);
        pick_t       res;
        int unsigned j;
        res = '0;
        for (int unsigned i = 0; i < NREQ_MAX; i++) begin
            if (i < nreq) begin
                j = ptr + i;
                if (j >= nreq) begin
                    j = j - nreq;
                end
                if (!res.valid && req[j]) begin
                    res.valid = 1'b1;
                    res.idx   = j;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/timer_share_ctrl_cnt_core.sv
// W-bit shared up-counter; clear wins over enable.
module cnt_core
    import timer_share_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear, increment or hold.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register, asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/timer_share_ctrl.sv
// Round-robin owner of one shared interval counter among NREQ requesters.
module timer_share_ctrl
    import timer_share_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned W    = W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] len,
    input  logic              abort,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic [W-1:0]      count
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   own_q, own_d;
    logic [IW-1:0]   own_inc;
    logic [W-1:0]    tgt_q, tgt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            cnt_clr;
    logic            cnt_en;
    pick_t           pick;

    cnt_core #(.W(W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (count)
    );

    // Arbitration candidate and the pointer value after the current owner.
    always_comb begin
        pick    = rr_pick(NREQ_MAX'(req), 32'(ptr_q), NREQ);
        own_inc = (own_q == IW'(NREQ - 1)) ? '0 : own_q + IW'(1);
    end

    // Next state, registered outputs and counter control.
    // Counter is cleared on every path into IDLE so count reads 0 whenever idle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        tgt_d   = tgt_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (pick.valid) begin
                    own_d            = IW'(pick.idx);
                    tgt_d            = len[pick.idx*W +: W];
                    gnt_d            = '0;
                    gnt_d[pick.idx]  = 1'b1;
                    state_d          = RUN;
                end
            end
            RUN: begin
                if (abort || !req[own_q]) begin
                    cnt_clr = 1'b1;
                    gnt_d   = '0;
                    ptr_d   = own_inc;
                    state_d = IDLE;
                end else if (count == tgt_q) begin
                    done_d[own_q] = 1'b1;
                    state_d       = DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE: begin
                cnt_clr = 1'b1;
                gnt_d   = '0;
                ptr_d   = own_inc;
                state_d = IDLE;
            end
            default: begin
                cnt_clr = 1'b1;
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Controller registers, asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            own_q   <= '0;
            tgt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            tgt_q   <= tgt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign busy = (state_q != IDLE);

endmodule
